// File: rtl/ram_stream_loader.sv
// Byte-stream to 32-bit word loader for a single-port on-chip RAM.
// Optional post-load read-back checksum verify: define RAM_LOADER_VERIFY_EN.
module ram_stream_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata,
   output logic              verify_ok,
   output logic              verify_fail
);

   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_WRITE,
`ifdef RAM_LOADER_VERIFY_EN
      S_VERIFY,
`endif
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic [1:0]          r_byte_idx;
   logic [3:0]          r_mask;
   logic [DATA_W-1:0]   r_word;
   logic                r_last;
   logic                r_overflow;
   logic [ADDR_W:0]     r_wc;
   logic                w_accept;
   logic                w_discard;

   assign w_accept  = (r_state == S_FILL) && in_valid;
   // Once DEPTH words are written every further byte is dropped until in_last.
   assign w_discard = r_overflow || (r_wc == FULL);

`ifdef RAM_LOADER_VERIFY_EN
   logic [ADDR_W-1:0]   r_base;
   logic [3:0]          r_last_be;
   logic [DATA_W-1:0]   r_wsum;
   logic [DATA_W-1:0]   r_rsum;
   logic [ADDR_W+1:0]   r_vcnt;
   logic                r_vok;
   logic                r_vfail;
   logic [ADDR_W+1:0]   w_wc_ext;
   logic [DATA_W-1:0]   w_rmask;

   assign w_wc_ext = {1'b0, r_wc};
   // Read data for issue slot k arrives in slot k+1; the last one is lane-masked.
   assign w_rmask  = (r_vcnt == w_wc_ext) ?
                     {{8{r_last_be[3]}}, {8{r_last_be[2]}}, {8{r_last_be[1]}}, {8{r_last_be[0]}}} :
                     {DATA_W{1'b1}};
   assign verify_ok   = r_vok;
   assign verify_fail = r_vfail;
`else
   logic w_unused_rdata;
   assign w_unused_rdata = ^ram_readdata;
   assign verify_ok      = 1'b0;
   assign verify_fail    = 1'b0;
`endif

   assign overflow   = r_overflow;
   assign word_count = r_wc;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // NOTE: the default assignment at the top keeps this block free of latches.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_FILL;
         S_FILL: begin
            if (w_accept) begin
               if (w_discard) begin
                  if (in_last) w_next_state = S_DONE;
               end else if ((r_byte_idx == 2'd3) || in_last) begin
                  w_next_state = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (!r_last)
               w_next_state = S_FILL;
            else
`ifdef RAM_LOADER_VERIFY_EN
               w_next_state = S_VERIFY;
`else
               w_next_state = S_DONE;
`endif
         end
`ifdef RAM_LOADER_VERIFY_EN
         S_VERIFY: if (r_vcnt == w_wc_ext + 1'b1) w_next_state = S_DONE;
`endif
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready       = (r_state == S_FILL);
      busy           = (r_state != S_IDLE) && (r_state != S_DONE);
      done           = (r_state == S_DONE);
      ram_clken      = busy;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      ram_address    = '0;
      ram_byteenable = 4'h0;
      ram_writedata  = '0;
      case (r_state)
         S_WRITE: begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_address    = r_ptr;
            ram_byteenable = r_mask;
            ram_writedata  = r_word;
         end
`ifdef RAM_LOADER_VERIFY_EN
         S_VERIFY: begin
            if (r_vcnt < w_wc_ext) begin
               ram_chipselect = 1'b1;
               ram_address    = r_base + r_vcnt[ADDR_W-1:0];
               ram_byteenable = 4'hF;
            end
         end
`endif
         default: ;
      endcase
   end

   // NOTE: the datapath is a handful of flops, so all of it is reset asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr      <= '0;
         r_byte_idx <= '0;
         r_mask     <= '0;
         r_word     <= '0;
         r_last     <= 1'b0;
         r_overflow <= 1'b0;
         r_wc       <= '0;
`ifdef RAM_LOADER_VERIFY_EN
         r_base     <= '0;
         r_last_be  <= '0;
         r_wsum     <= '0;
         r_rsum     <= '0;
         r_vcnt     <= '0;
         r_vok      <= 1'b0;
         r_vfail    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ptr      <= base_addr;
                  r_byte_idx <= '0;
                  r_mask     <= '0;
                  r_word     <= '0;
                  r_last     <= 1'b0;
                  r_overflow <= 1'b0;
                  r_wc       <= '0;
`ifdef RAM_LOADER_VERIFY_EN
                  r_base     <= base_addr;
                  r_wsum     <= '0;
                  r_rsum     <= '0;
                  r_vcnt     <= '0;
                  r_vok      <= 1'b0;
                  r_vfail    <= 1'b0;
`endif
               end
            end
            S_FILL: begin
               if (w_accept) begin
                  if (w_discard) begin
                     r_overflow <= 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
                     if (in_last) r_vfail <= 1'b1;
`endif
                  end else begin
                     r_word[{r_byte_idx, 3'b000} +: 8] <= in_data;
                     r_mask[r_byte_idx]                <= 1'b1;
                     r_byte_idx                        <= r_byte_idx + 2'd1;
                     r_last                            <= in_last;
                  end
               end
            end
            S_WRITE: begin
               r_ptr      <= r_ptr + 1'b1;
               r_wc       <= r_wc + 1'b1;
               r_mask     <= '0;
               r_byte_idx <= '0;
               r_word     <= '0;
`ifdef RAM_LOADER_VERIFY_EN
               r_wsum     <= r_wsum + r_word;
               r_last_be  <= r_mask;
`endif
            end
`ifdef RAM_LOADER_VERIFY_EN
            S_VERIFY: begin
               r_vcnt <= r_vcnt + 1'b1;
               if ((r_vcnt != '0) && (r_vcnt <= w_wc_ext))
                  r_rsum <= r_rsum + (ram_readdata & w_rmask);
               if (r_vcnt == w_wc_ext + 1'b1) begin
                  r_vok   <= (r_rsum == r_wsum);
                  r_vfail <= (r_rsum != r_wsum);
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
